dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Two-port arbiter and sequencer for the single-ported synchronous data memory (DM).
- Port 0 is driven by the AHB slave wrapper side; port 1 is driven by a second requester (CPU direct/DMA).
- Grants one access at a time, drives DM_enable/DM_address/DM_in/DM_write from registered state, and returns read data with a done pulse.
- Round-robin or fixed priority, selectable by parameter.

Parameters:
- DATA_W, 32, data and address width (matches `data_size).
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- p0_req  input  1  port 0 access request (level; held until p0_done).
- p0_write  input  1  port 0: 1 = write, 0 = read.
- p0_addr  input  DATA_W  port 0 address.
- p0_wdata  input  DATA_W  port 0 write data.
- p0_done  output  1  port 0 completion pulse (1 cycle).
- p0_rdata  output  DATA_W  port 0 read data; valid with p0_done, held until the next port 0 read.
- p1_req, p1_write, p1_addr, p1_wdata, p1_done, p1_rdata: same as port 0, for port 1.
- DM_out  input  DATA_W  DM read data, valid one cycle after an enabled read cycle.
- DM_enable  output  1  DM chip enable.
- DM_address  output  DATA_W  DM address.
- DM_in  output  DATA_W  DM write data.
- DM_write  output  1  DM write enable.
- busy  output  1  1 whenever state != IDLE.
- owner  output  1  port currently granted; holds last value when idle.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0, including p*_rdata and owner.
  - Priority pointer set so port 0 wins the first tie.
- States: IDLE, ACCESS, RWAIT, DONE.
- Sampling points: IDLE and DONE. If any req is high, pick a winner and register addr/wdata/write/owner. Next state = ACCESS; otherwise IDLE.
- Arbitration:
  - RR_EN=1: single request wins outright. Both high: the port not granted last wins. Pointer updates on every grant.
  - RR_EN=0: port 0 wins whenever p0_req=1.
- ACCESS (1 cycle):
  - DM_enable=1; DM_address, DM_in and DM_write come from the registered request.
  - Write: next state = DONE.
  - Read: next state = RWAIT, with DM_in=0.
- RWAIT (1 cycle):
  - DM_enable=1, DM_write=0, address held.
  - DM_out is captured into the owner's rdata register at the end of this cycle.
  - Next state = DONE.
- DONE (1 cycle):
  - Owner's p*_done=1; DM_enable=0.
  - Samples requests as in IDLE. The completing port's req is ignored for this sample, so the requester can drop it.
- Latency from req sampled:
  - Write: done in cycle +2 (DM written in cycle +1).
  - Read: done in cycle +3.
- Back-to-back: DONE→ACCESS without IDLE. Minimum period is 2 cycles per write and 3 per read.
- Outside ACCESS/RWAIT: DM_enable=0, DM_write=0, DM_address=0, DM_in=0.
- The non-owner's rdata register is never modified. The non-owner's done stays 0.
- A req dropped mid-transaction does not abort; the access completes and done still pulses.
- Address, data and write are latched at grant. Input changes after grant have no effect on the current access.
- Reset asserted mid-transaction: immediate return to reset values. No done pulse; the partial DM access is abandoned.
- The arbiter never asserts both done outputs in the same cycle. It never drives DM for two ports in one cycle.

Test Plan:
- Port 0 write: p0_req=1, p0_write=1, p0_addr=0x0000_0010, p0_wdata=0xDEAD_BEEF → cycle+1: DM_enable=1, DM_write=1, DM_address=0x10, DM_in=0xDEADBEEF; cycle+2: p0_done=1, p1_done=0.
- Port 1 read: DM model returns 0x1234_5678 for addr 0x20; p1_req=1, p1_write=0 → ACCESS and RWAIT with DM_write=0; cycle+3: p1_done=1, p1_rdata=0x12345678; p0_rdata unchanged (0).
- Contention, RR_EN=1: both req held high, both reads → grants alternate 0,1,0,1; done pulses every 3 cycles; no idle cycle between transactions.
- Contention, RR_EN=0: both req held high → port 0 granted every transaction; p1_done never asserts while p0_req=1.
- Request drop: p0 read granted, p0_req deasserted during ACCESS → access completes and p0_done pulses at cycle+3.
- Reset mid-read: rst=0 during RWAIT → same cycle: DM_enable=0, busy=0, no done pulse; after release, a new p1 write completes in 2 cycles.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Two-port arbiter/sequencer for the single-ported synchronous data memory.
//   Port 0 serves the AHB slave wrapper; port 1 serves a second requester
//   (CPU direct / DMA). One access is granted at a time. All DM-side and
//   handshake outputs come straight from registers.
//
// Parameters
//   DATA_W : data/address width
//   RR_EN  : 1 = round-robin, 0 = fixed priority (port 0 always wins)
//
// Ports
//   clk, rst                   : clock, asynchronous active-low reset
//   p*_req/write/addr/wdata    : port request (level, held until p*_done)
//   p*_done                    : one-cycle completion pulse
//   p*_rdata                   : read data, valid with p*_done, held afterwards
//   DM_out                     : memory read data (one cycle after enabled read)
//   DM_enable/address/in/write : memory control
//   busy                       : 1 whenever not IDLE
//   owner                      : currently/last granted port
module dm_arbiter #(
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_write,
    input  logic [DATA_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_write,
    input  logic [DATA_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic [DATA_W-1:0] DM_out,
    output logic              DM_enable,
    output logic [DATA_W-1:0] DM_address,
    output logic [DATA_W-1:0] DM_in,
    output logic              DM_write,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, DONE} state_t;

    state_t state;
    logic   last_grant;   // port granted most recently (round-robin pointer)
    logic   req0_eff;
    logic   req1_eff;
    logic   win;
    logic   win_write;

    // While completing, the owner's still-high req is ignored so it can drop it.
    // Under fixed priority port 0 is exempt: a held p0_req always wins again.
    always_comb begin
        req0_eff = p0_req;
        req1_eff = p1_req;
        if (state == DONE) begin
            if (!owner && RR_EN) req0_eff = 1'b0;
            if (owner)           req1_eff = 1'b0;
        end
        if (req0_eff && req1_eff) win = RR_EN ? ~last_grant : 1'b0;
        else                      win = req1_eff;
        win_write = win ? p1_write : p0_write;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;   // port 0 wins the first tie
            owner      <= 1'b0;
            busy       <= 1'b0;
            p0_done    <= 1'b0;
            p1_done    <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            DM_enable  <= 1'b0;
            DM_write   <= 1'b0;
            DM_address <= '0;
            DM_in      <= '0;
        end else begin
            p0_done <= 1'b0;
            p1_done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (req0_eff || req1_eff) begin
                        // Request is latched into the DM output registers at grant.
                        state      <= ACCESS;
                        busy       <= 1'b1;
                        owner      <= win;
                        last_grant <= win;
                        DM_enable  <= 1'b1;
                        DM_write   <= win_write;
                        DM_address <= win ? p1_addr : p0_addr;
                        DM_in      <= win_write ? (win ? p1_wdata : p0_wdata) : '0;
                    end else begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        DM_enable  <= 1'b0;
                        DM_write   <= 1'b0;
                        DM_address <= '0;
                        DM_in      <= '0;
                    end
                end
                ACCESS: begin
                    if (DM_write) begin
                        state      <= DONE;
                        DM_enable  <= 1'b0;
                        DM_write   <= 1'b0;
                        DM_address <= '0;
                        DM_in      <= '0;
                        if (owner) p1_done <= 1'b1;
                        else       p0_done <= 1'b1;
                    end else begin
                        state <= RWAIT;   // enable/address held for the data cycle
                    end
                end
                RWAIT: begin
                    state      <= DONE;
                    DM_enable  <= 1'b0;
                    DM_address <= '0;
                    if (owner) begin
                        p1_rdata <= DM_out;
                        p1_done  <= 1'b1;
                    end else begin
                        p0_rdata <= DM_out;
                        p0_done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
